// File: rtl/bus_cycle_seq.sv
// External-bus cycle sequencer: accepts a transfer request, splits it into
// memory-port-sized beats, inserts wait states, and generates the timing and
// qualifier strobes for the bus data-path steering logic.
module bus_cycle_seq #(
  parameter int unsigned WS_BITS = 4
) (
  input  logic               sys_clk,
  input  logic               resetl,
  input  logic               req,
  input  logic               req_read,
  input  logic [1:0]         req_width,
  input  logic [2:0]         req_addr,
  input  logic [1:0]         mem_width,
  input  logic [WS_BITS-1:0] wait_states,
  input  logic               intdev,
  output logic               ack,
  output logic               ourack,
  output logic               done,
  output logic               idle,
  output logic               reads,
  output logic               erd,
  output logic [2:0]         ba,
  output logic               mws8,
  output logic               mws16,
  output logic               mws64
);

  localparam int unsigned BEAT_BITS = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  logic [1:0]           state,    state_nxt;
  logic [WS_BITS-1:0]   wcnt,     wcnt_nxt;
  logic [BEAT_BITS-1:0] beats,    beats_nxt;
  logic [2:0]           ba_nxt;
  logic                 reads_nxt;
  logic                 intdev_q, intdev_nxt;
  logic [1:0]           mw_q,     mw_nxt;
  logic [WS_BITS-1:0]   ws_q,     ws_nxt;
  logic [2:0]           mws_q,    mws_nxt;
  logic [WS_BITS-1:0]   ws_load;
  logic                 idle_nxt, ourack_nxt, done_nxt, erd_nxt;

  // Request acceptance is the only combinational handshake; gated by reset
  // so nothing is acknowledged while the sequencer is being cleared.
  assign ack = req && (state == S_IDLE) && resetl;

  assign mws8  = mws_q[2];
  assign mws16 = mws_q[1];
  assign mws64 = mws_q[0];

  // Next-state, field capture and registered-output decode.
  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    beats_nxt  = beats;
    ba_nxt     = ba;
    reads_nxt  = reads;
    intdev_nxt = intdev_q;
    mw_nxt     = mw_q;
    ws_nxt     = ws_q;
    mws_nxt    = mws_q;
    ws_load    = intdev_q ? '0 : ws_q;

    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt  = S_ADDR;
          reads_nxt  = req_read;
          intdev_nxt = intdev;
          mw_nxt     = mem_width;
          ws_nxt     = wait_states;
          ba_nxt     = req_addr;
          beats_nxt  = (req_width > mem_width) ?
                       (BEAT_BITS'(1) << (req_width - mem_width)) : BEAT_BITS'(1);
          mws_nxt    = {mem_width == 2'd0, mem_width == 2'd1, mem_width == 2'd3};
        end
      end
      S_ADDR: begin
        wcnt_nxt  = ws_load;
        state_nxt = (ws_load != '0) ? S_WAIT : S_DATA;
      end
      S_WAIT: begin
        wcnt_nxt = wcnt - WS_BITS'(1);
        if (wcnt == WS_BITS'(1)) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (beats == BEAT_BITS'(1)) begin
          state_nxt = S_IDLE;
        end else begin
          beats_nxt = beats - BEAT_BITS'(1);
          ba_nxt    = ba + (3'(1) << mw_q);
          state_nxt = S_ADDR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    idle_nxt   = (state_nxt == S_IDLE);
    ourack_nxt = (state_nxt == S_DATA);
    done_nxt   = ourack_nxt && (beats_nxt == BEAT_BITS'(1));
    erd_nxt    = !idle_nxt && reads_nxt && !intdev_nxt;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      beats    <= '0;
      ba       <= '0;
      reads    <= 1'b0;
      intdev_q <= 1'b0;
      mw_q     <= '0;
      ws_q     <= '0;
      mws_q    <= '0;
      idle     <= 1'b1;
      ourack   <= 1'b0;
      done     <= 1'b0;
      erd      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      beats    <= beats_nxt;
      ba       <= ba_nxt;
      reads    <= reads_nxt;
      intdev_q <= intdev_nxt;
      mw_q     <= mw_nxt;
      ws_q     <= ws_nxt;
      mws_q    <= mws_nxt;
      idle     <= idle_nxt;
      ourack   <= ourack_nxt;
      done     <= done_nxt;
      erd      <= erd_nxt;
    end
  end

endmodule

// File: tb/tb_bus_cycle_seq.sv
// Scoreboard bench for bus_cycle_seq: stimulus queues expected beats at ack,
// a negedge monitor pops and compares at every ourack.
module tb_bus_cycle_seq;

  logic       sys_clk = 1'b0;
  logic       resetl;
  logic       req;
  logic       req_read;
  logic [1:0] req_width;
  logic [2:0] req_addr;
  logic [1:0] mem_width;
  logic [3:0] wait_states;
  logic       intdev;
  logic       ack, ourack, done, idle, reads, erd;
  logic [2:0] ba;
  logic       mws8, mws16, mws64;

  bus_cycle_seq #(.WS_BITS(4)) dut (
    .sys_clk(sys_clk), .resetl(resetl), .req(req), .req_read(req_read),
    .req_width(req_width), .req_addr(req_addr), .mem_width(mem_width),
    .wait_states(wait_states), .intdev(intdev), .ack(ack), .ourack(ourack),
    .done(done), .idle(idle), .reads(reads), .erd(erd), .ba(ba),
    .mws8(mws8), .mws16(mws16), .mws64(mws64)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0] ba;
    logic       done;
    logic       erd;
    logic       reads;
    logic [2:0] mws;
    int         cyc;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  logic  cur_erd   = 1'b0;
  logic  cur_reads = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: per-beat scoreboard pop plus per-cycle strobe invariants.
  always @(negedge sys_clk) begin
    if (resetl === 1'b1) begin
      chk("ack_and_ourack", 32'(ack & ourack), 32'd0);
      chk("done_without_ourack", 32'(done & ~ourack), 32'd0);
      if (!idle) begin
        chk("erd_active", 32'(erd), 32'(cur_erd));
        chk("reads_active", 32'(reads), 32'(cur_reads));
        chk("ack_outside_idle", 32'(ack), 32'd0);
      end
      if (ourack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ourack", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_ba", 32'(ba), 32'(e.ba));
          chk("beat_done", 32'(done), 32'(e.done));
          chk("beat_erd", 32'(erd), 32'(e.erd));
          chk("beat_reads", 32'(reads), 32'(e.reads));
          chk("beat_mws", 32'({mws8, mws16, mws64}), 32'(e.mws));
          chk("beat_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // One transfer: drive request, wait for ack, queue expected beats, wait for done.
  task automatic xfer(input logic rd, input logic [1:0] w, input logic [2:0] a,
                      input logic [1:0] mw, input logic [3:0] ws, input logic intd,
                      input logic hold, output int ack_wait);
    int nb, blen, n;
    logic [2:0] stride, addr;
    logic [2:0] mws_e;
    beat_t e;
    @(negedge sys_clk);
    req = 1'b1; req_read = rd; req_width = w; req_addr = a;
    mem_width = mw; wait_states = ws; intdev = intd;
    ack_wait = 0;
    #1;
    while (!ack && ack_wait < 20) begin
      @(negedge sys_clk); #1; ack_wait++;
    end
    if (!ack) begin
      chk("ack_timeout", 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    chk("idle_at_ack", 32'(idle), 32'd1);
    nb     = (w > mw) ? (1 << (w - mw)) : 1;
    blen   = 2 + (intd ? 0 : int'(ws));
    stride = 3'(1 << mw);
    case (mw)
      2'd0:    mws_e = 3'b100;
      2'd1:    mws_e = 3'b010;
      2'd3:    mws_e = 3'b001;
      default: mws_e = 3'b000;
    endcase
    cur_erd   = rd & ~intd;
    cur_reads = rd;
    addr = a;
    for (int k = 0; k < nb; k++) begin
      e.ba    = addr;
      e.done  = (k == nb - 1);
      e.erd   = rd & ~intd;
      e.reads = rd;
      e.mws   = mws_e;
      e.cyc   = cyc + (k + 1) * blen;
      sb.push_back(e);
      addr = addr + stride;
    end
    @(posedge sys_clk); #1;
    if (!hold) req = 1'b0;
    req_width = ~w; req_addr = a + 3'd3; mem_width = ~mw;
    wait_states = ~ws; intdev = ~intd; req_read = ~rd;
    n = 0;
    @(negedge sys_clk);
    while (!done && n < 300) begin
      @(negedge sys_clk); n++;
    end
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    if (!hold) begin
      @(negedge sys_clk);
      chk("idle_after_done", 32'(idle), 32'd1);
      chk("erd_after_done", 32'(erd), 32'd0);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw;
    resetl = 1'b0; req = 1'b0; req_read = 1'b0; req_width = 2'd0;
    req_addr = 3'd0; mem_width = 2'd0; wait_states = 4'd0; intdev = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ourack", 32'(ourack), 32'd0);
    chk("rst_erd", 32'(erd), 32'd0);
    chk("rst_ba", 32'(ba), 32'd0);
    resetl = 1'b1;

    // T1: reset asserted mid-WAIT abandons the transfer.
    @(negedge sys_clk);
    req = 1'b1; req_read = 1'b1; req_width = 2'd3; req_addr = 3'd2;
    mem_width = 2'd0; wait_states = 4'd5; intdev = 1'b0;
    cur_erd = 1'b1; cur_reads = 1'b1;
    #1 chk("t1_ack", 32'(ack), 32'd1);
    @(posedge sys_clk); #1 req = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("t1_busy", 32'(idle), 32'd0);
    chk("t1_mws8", 32'(mws8), 32'd1);
    resetl = 1'b0;
    @(posedge sys_clk); #1;
    chk("t1_idle", 32'(idle), 32'd1);
    chk("t1_ack0", 32'(ack), 32'd0);
    chk("t1_ourack", 32'(ourack), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_erd", 32'(erd), 32'd0);
    chk("t1_reads", 32'(reads), 32'd0);
    chk("t1_mws", 32'({mws8, mws16, mws64}), 32'd0);
    chk("t1_ba", 32'(ba), 32'd0);
    @(negedge sys_clk); resetl = 1'b1;

    // T2: 32-bit read, 32-bit port, no waits.
    xfer(1'b1, 2'd2, 3'd4, 2'd2, 4'd0, 1'b0, 1'b0, aw);
    // T3: 64-bit read on 8-bit port, 2 waits: 8 beats.
    xfer(1'b1, 2'd3, 3'd0, 2'd0, 4'd2, 1'b0, 1'b0, aw);
    // T4: 32-bit write on 16-bit port, addr 6 wraps to 0.
    xfer(1'b0, 2'd2, 3'd6, 2'd1, 4'd1, 1'b0, 1'b0, aw);
    // T5: internal device ignores 15 wait states.
    xfer(1'b1, 2'd3, 3'd0, 2'd3, 4'd15, 1'b1, 1'b0, aw);
    // T6: req held through done, fields scrambled mid-transfer.
    xfer(1'b1, 2'd1, 3'd3, 2'd0, 4'd0, 1'b0, 1'b1, aw);
    xfer(1'b0, 2'd0, 3'd7, 2'd2, 4'd3, 1'b0, 1'b0, aw);
    chk("t6_back_to_back_ack_wait", 32'(aw), 32'd0);

    repeat (5) @(negedge sys_clk);
    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
